mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage 16-bit pipeline. Sits between the EX_MEM buffer and the write-back stage.
- Performs loads and stores, plus stack push/pop through an internal stack pointer (SP). Supports two-word (32-bit) push/pop for call/return/interrupt PC save.
- Drives a word-addressed data memory with asynchronous read and synchronous write.
- Registers its results into the MEM_WB fields (internal MEM_WB register) consumed by write-back. Stalls upstream during two-cycle wide operations.

Parameters:
- ADDR_W, 11, data-memory word-address width.
- SP_INIT, 11'h7FF, SP value after reset (top of memory).

Ports:
- clk  in  1  pipeline clock; one clock domain. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- mem_read_in  in  1  load from addr_in.
- mem_write_in  in  1  store store_data_in to addr_in.
- push_in  in  1  stack push.
- pop_in  in  1  stack pop.
- wide_in  in  1  push/pop is 32-bit (two words).
- addr_in  in  16  effective address; low ADDR_W bits used.
- store_data_in  in  32  push/store data; [15:0] for single-word ops.
- Rdst1_in, Rdst2_in  in  3 each  destination register indices, passed through.
- Rdst1_val_in, Rdst2_val_in  in  16 each  ALU results, passed through.
- reglow_write_in, reghigh_write_in  in  1 each  register-write enables, passed through.
- memToReg_in  in  1  passed through; write-back selects Data_out when set.
- dmem_rdata  in  16  asynchronous read data from data memory.
- dmem_addr  out  ADDR_W  memory address.
- dmem_wdata  out  16  memory write data.
- dmem_we  out  1  memory write enable (sampled at clk rising edge).
- stall_out  out  1  hold IF/ID/EX and EX_MEM; combinational.
- Data_out  out  16  registered loaded/popped low word.
- Data_wide_out  out  32  registered popped 32-bit value, {high, low}.
- wide_valid_out  out  1  registered; Data_wide_out is valid this cycle.
- Rdst1_out, Rdst2_out, Rdst1_val_out, Rdst2_val_out, reglow_write_out, reghigh_write_out, memToReg_out  out  —  registered pass-throughs.
- sp_out  out  ADDR_W  current SP (debug/forwarding).

Behaviour:
- Reset, at the clk edge with rst=1:
  - all registered outputs = 0;
  - SP = SP_INIT;
  - FSM = IDLE.
  - Reset mid wide-op aborts it. A first-word write already performed stays in memory.
- FSM states: IDLE, WIDE2.
- IDLE, single-word op. One cycle; stall_out = 0. Results are registered at the next edge (latency 1).
  - Load: dmem_addr = addr_in; Data_out <= dmem_rdata.
  - Store: dmem_we = 1; dmem_wdata = store_data_in[15:0].
  - Push: dmem_addr = SP; dmem_wdata = store_data_in[15:0]; dmem_we = 1; SP <= SP-1.
  - Pop: dmem_addr = SP+1; Data_out <= dmem_rdata; SP <= SP+1.
- IDLE, wide op (push_in or pop_in, with wide_in = 1):
  - stall_out = 1 for this cycle. Go to WIDE2.
  - Write enables in the pass-through bundle are registered as 0 (bubble to write-back).
  - First word:
    - push writes store_data_in[31:16] at SP;
    - pop reads SP+1 (low word) into an internal latch.
- WIDE2: stall_out = 0. Inputs are held by upstream (stable).
  - Second word:
    - push writes store_data_in[15:0] at SP-1, then SP <= SP-2;
    - pop reads SP+2 (high word), then SP <= SP+2.
  - For pop, register Data_wide_out = {high, low}, wide_valid_out = 1, Data_out = low.
  - Register the pass-throughs. Return to IDLE.
- wide_valid_out is high for exactly one cycle per wide pop; 0 otherwise.
- SP arithmetic is modulo 2^ADDR_W. Wrap-around is silent: 11'h7FF+1 = 0; 0-1 = 11'h7FF.
- Simultaneous requests, priority: push > pop > store > load.
  - Lower-priority requests are ignored.
  - mem_read_in with mem_write_in performs the store only. Data_out holds its previous value.
- No op asserted: dmem_we = 0, dmem_addr = addr_in. Pass-throughs are registered every non-stall cycle.
- dmem_we is never asserted while rst = 1.

Optional Feature:
- Macro: STACK_GUARD_EN.
- When defined:
  - add output stack_fault (1 bit, registered, reset 0).
  - A push at SP = 0 (wide: SP ≤ 1) or a pop at SP = SP_INIT (wide: SP ≥ SP_INIT-1) is suppressed: no dmem_we, SP unchanged, register enables forced 0.
  - stack_fault = 1 for one cycle after the suppressed op's final cycle.
- When undefined: no port; wrap-around as above.

Test Plan:
- Reset, then idle -> sp_out=11'h7FF; all outputs 0; stall_out=0; dmem_we=0.
- Push 16'hBEEF, then pop with memToReg_in=1, Rdst1_in=3 -> push writes mem[7FF]=BEEF and sp_out=7FE. One cycle after the pop, Data_out=BEEF, Rdst1_out=3, sp_out=7FF.
- Wide push 32'h1234_5678 -> stall_out high for one cycle; mem[7FF]=1234, mem[7FE]=5678; sp_out=7FD; write enables bubble then pass through. Then wide pop -> Data_wide_out=32'h1234_5678, wide_valid_out pulses once, sp_out=7FF.
- Store 16'h00AA at addr 16'h0010, then load 16'h0010 -> mem[010]=00AA; Data_out=00AA one cycle after the load.
- push_in and mem_write_in both asserted with SP=7FF -> only mem[7FF] written; store address untouched. Pop at SP=7FF (no guard) -> reads mem[000]; sp_out=000.
- Assert rst during the WIDE2 cycle of a wide push -> second word not written; SP=7FF; FSM in IDLE; outputs 0. With STACK_GUARD_EN, pop at SP=7FF -> stack_fault=1 for one cycle; SP unchanged.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: loads, stores, and SP-based push/pop with two-cycle 32-bit push/pop.
// Optional macro STACK_GUARD_EN adds stack_fault and suppresses stack over/underflowing ops.
module mem_stage #(
  parameter int                ADDR_W  = 11,
  parameter logic [ADDR_W-1:0] SP_INIT = 11'h7FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic              wide_in,
  input  logic [15:0]       addr_in,
  input  logic [31:0]       store_data_in,
  input  logic [2:0]        Rdst1_in,
  input  logic [2:0]        Rdst2_in,
  input  logic [15:0]       Rdst1_val_in,
  input  logic [15:0]       Rdst2_val_in,
  input  logic              reglow_write_in,
  input  logic              reghigh_write_in,
  input  logic              memToReg_in,
  input  logic [15:0]       dmem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  output logic              dmem_we,
  output logic              stall_out,
  output logic [15:0]       Data_out,
  output logic [31:0]       Data_wide_out,
  output logic              wide_valid_out,
  output logic [2:0]        Rdst1_out,
  output logic [2:0]        Rdst2_out,
  output logic [15:0]       Rdst1_val_out,
  output logic [15:0]       Rdst2_val_out,
  output logic              reglow_write_out,
  output logic              reghigh_write_out,
  output logic              memToReg_out,
`ifdef STACK_GUARD_EN
  output logic              stack_fault,
`endif
  output logic [ADDR_W-1:0] sp_out
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WIDE2 = 1'b1;
  localparam logic [ADDR_W-1:0] SP_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] SP_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] SP_TWO  = {{(ADDR_W-2){1'b0}}, 2'b10};

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              wide_push_q, wide_push_d;
  logic              guard_q, guard_d;
  logic [15:0]       low_q, low_d;
  logic [15:0]       data_q;
  logic [31:0]       data_wide_q;
  logic              wide_valid_q;
  logic [2:0]        rdst1_q, rdst2_q;
  logic [15:0]       rdst1_val_q, rdst2_val_q;
  logic              reglow_q, reghigh_q, mem_to_reg_q;
  logic              we_s, capture_s, wide_done_s, suppress_s;
  logic              push_guard_s, pop_guard_s;
  logic              addr_unused_s;

  assign addr_unused_s = ^addr_in[15:ADDR_W];

`ifdef STACK_GUARD_EN
  assign push_guard_s = wide_in ? (sp_q <= SP_ONE) : (sp_q == SP_ZERO);
  assign pop_guard_s  = wide_in ? (sp_q >= (SP_INIT - SP_ONE)) : (sp_q == SP_INIT);
`else
  assign push_guard_s = 1'b0;
  assign pop_guard_s  = 1'b0;
`endif

  // Op decode (push > pop > store > load), memory port drive and next-state
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    wide_push_d = wide_push_q;
    guard_d     = guard_q;
    low_d       = low_q;
    dmem_addr   = addr_in[ADDR_W-1:0];
    dmem_wdata  = store_data_in[15:0];
    we_s        = 1'b0;
    stall_out   = 1'b0;
    capture_s   = 1'b0;
    wide_done_s = 1'b0;
    suppress_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (push_in) begin
          dmem_addr = sp_q;
          if (wide_in) begin
            dmem_wdata  = store_data_in[31:16];
            we_s        = ~push_guard_s;
            stall_out   = 1'b1;
            suppress_s  = 1'b1;
            state_d     = ST_WIDE2;
            wide_push_d = 1'b1;
            guard_d     = push_guard_s;
          end else if (push_guard_s) begin
            suppress_s = 1'b1;
          end else begin
            we_s = 1'b1;
            sp_d = sp_q - SP_ONE;
          end
        end else if (pop_in) begin
          dmem_addr = sp_q + SP_ONE;
          if (wide_in) begin
            low_d       = dmem_rdata;
            stall_out   = 1'b1;
            suppress_s  = 1'b1;
            state_d     = ST_WIDE2;
            wide_push_d = 1'b0;
            guard_d     = pop_guard_s;
          end else if (pop_guard_s) begin
            suppress_s = 1'b1;
          end else begin
            capture_s = 1'b1;
            sp_d      = sp_q + SP_ONE;
          end
        end else if (mem_write_in) begin
          we_s = 1'b1;
        end else if (mem_read_in) begin
          capture_s = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      ST_WIDE2: begin
        state_d = ST_IDLE;
        if (guard_q) begin
          suppress_s = 1'b1;
        end else if (wide_push_q) begin
          dmem_addr = sp_q - SP_ONE;
          we_s      = 1'b1;
          sp_d      = sp_q - SP_TWO;
        end else begin
          dmem_addr   = sp_q + SP_TWO;
          wide_done_s = 1'b1;
          sp_d        = sp_q + SP_TWO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dmem_we = we_s & ~rst;

  // Stage state and MEM_WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sp_q         <= SP_INIT;
      wide_push_q  <= 1'b0;
      guard_q      <= 1'b0;
      low_q        <= 16'h0000;
      data_q       <= 16'h0000;
      data_wide_q  <= 32'h0000_0000;
      wide_valid_q <= 1'b0;
      rdst1_q      <= 3'd0;
      rdst2_q      <= 3'd0;
      rdst1_val_q  <= 16'h0000;
      rdst2_val_q  <= 16'h0000;
      reglow_q     <= 1'b0;
      reghigh_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      wide_push_q <= wide_push_d;
      guard_q     <= guard_d;
      low_q       <= low_d;
      if (capture_s) begin
        data_q <= dmem_rdata;
      end else if (wide_done_s) begin
        data_q <= low_q;
      end
      if (wide_done_s) begin
        data_wide_q <= {dmem_rdata, low_q};
      end
      wide_valid_q <= wide_done_s;
      rdst1_q      <= Rdst1_in;
      rdst2_q      <= Rdst2_in;
      rdst1_val_q  <= Rdst1_val_in;
      rdst2_val_q  <= Rdst2_val_in;
      reglow_q     <= reglow_write_in & ~suppress_s;
      reghigh_q    <= reghigh_write_in & ~suppress_s;
      mem_to_reg_q <= memToReg_in;
    end
  end

`ifdef STACK_GUARD_EN
  logic fault_q, fault_d;

  // A suppressed op flags its fault on the edge ending its last cycle
  always_comb begin
    if (state_q == ST_WIDE2) begin
      fault_d = guard_q;
    end else if (push_in) begin
      fault_d = push_guard_s & ~wide_in;
    end else if (pop_in) begin
      fault_d = pop_guard_s & ~wide_in;
    end else begin
      fault_d = 1'b0;
    end
  end

  // Fault flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign stack_fault = fault_q;
`endif

  assign Data_out          = data_q;
  assign Data_wide_out     = data_wide_q;
  assign wide_valid_out    = wide_valid_q;
  assign Rdst1_out         = rdst1_q;
  assign Rdst2_out         = rdst2_q;
  assign Rdst1_val_out     = rdst1_val_q;
  assign Rdst2_val_out     = rdst2_val_q;
  assign reglow_write_out  = reglow_q;
  assign reghigh_write_out = reghigh_q;
  assign memToReg_out      = mem_to_reg_q;
  assign sp_out            = sp_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-cycle ops, then wide push/pop
// and reset-during-wide sequences. Data memory is modelled here (async read, sync write).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in, mem_write_in, push_in, pop_in, wide_in;
  logic [15:0] addr_in;
  logic [31:0] store_data_in;
  logic [2:0]  Rdst1_in, Rdst2_in;
  logic [15:0] Rdst1_val_in, Rdst2_val_in;
  logic        reglow_write_in, reghigh_write_in, memToReg_in;
  logic [15:0] dmem_rdata;
  logic [10:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we, stall_out;
  logic [15:0] Data_out;
  logic [31:0] Data_wide_out;
  logic        wide_valid_out;
  logic [2:0]  Rdst1_out, Rdst2_out;
  logic [15:0] Rdst1_val_out, Rdst2_val_out;
  logic        reglow_write_out, reghigh_write_out, memToReg_out;
  logic [10:0] sp_out;
`ifdef STACK_GUARD_EN
  logic        stack_fault;
`endif

  logic [15:0] mem [0:2047];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dmem_rdata = mem[dmem_addr];

  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
  end

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .push_in(push_in), .pop_in(pop_in), .wide_in(wide_in),
    .addr_in(addr_in), .store_data_in(store_data_in),
    .Rdst1_in(Rdst1_in), .Rdst2_in(Rdst2_in),
    .Rdst1_val_in(Rdst1_val_in), .Rdst2_val_in(Rdst2_val_in),
    .reglow_write_in(reglow_write_in), .reghigh_write_in(reghigh_write_in),
    .memToReg_in(memToReg_in), .dmem_rdata(dmem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .stall_out(stall_out), .Data_out(Data_out), .Data_wide_out(Data_wide_out),
    .wide_valid_out(wide_valid_out),
    .Rdst1_out(Rdst1_out), .Rdst2_out(Rdst2_out),
    .Rdst1_val_out(Rdst1_val_out), .Rdst2_val_out(Rdst2_val_out),
    .reglow_write_out(reglow_write_out), .reghigh_write_out(reghigh_write_out),
    .memToReg_out(memToReg_out),
`ifdef STACK_GUARD_EN
    .stack_fault(stack_fault),
`endif
    .sp_out(sp_out)
  );

  typedef struct {
    logic        rd, wr, push, pop;
    logic [15:0] addr;
    logic [31:0] sdata;
    logic [2:0]  rdst1;
    logic        rlw, mtr;
    logic        e_we;
    logic [10:0] e_addr;
    logic [15:0] e_wdata;
    logic [15:0] e_data;
    logic [10:0] e_sp;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read_in = 1'b0; mem_write_in = 1'b0; push_in = 1'b0; pop_in = 1'b0; wide_in = 1'b0;
    addr_in = 16'h0000; store_data_in = 32'h0; Rdst1_in = 3'd0; Rdst2_in = 3'd0;
    Rdst1_val_in = 16'h0; Rdst2_val_in = 16'h0;
    reglow_write_in = 1'b0; reghigh_write_in = 1'b0; memToReg_in = 1'b0;
  endtask

  initial begin
    // rd wr push pop addr sdata rdst1 rlw mtr | we addr wdata Data_out sp
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,16'h0005,32'h0000_0000,3'd0,1'b0,1'b0, 1'b0,11'h005,16'h0000,16'h0000,11'h7FF};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000,32'h0000_BEEF,3'd1,1'b0,1'b0, 1'b1,11'h7FF,16'hBEEF,16'h0000,11'h7FE};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,16'h0000,32'h0000_0000,3'd3,1'b1,1'b1, 1'b0,11'h7FF,16'h0000,16'hBEEF,11'h7FF};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,16'h0010,32'h0000_00AA,3'd2,1'b0,1'b0, 1'b1,11'h010,16'h00AA,16'hBEEF,11'h7FF};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,16'h0010,32'h0000_0000,3'd4,1'b1,1'b1, 1'b0,11'h010,16'h0000,16'h00AA,11'h7FF};
    vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,16'h0020,32'h0000_1111,3'd5,1'b0,1'b0, 1'b1,11'h020,16'h1111,16'h00AA,11'h7FF};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,16'h0030,32'h0000_5555,3'd6,1'b1,1'b0, 1'b1,11'h7FF,16'h5555,16'h00AA,11'h7FE};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b1,16'h0020,32'h0000_0000,3'd7,1'b1,1'b1, 1'b0,11'h7FF,16'h0000,16'h5555,11'h7FF};
`ifdef STACK_GUARD_EN
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,16'h0000,32'h0000_0000,3'd1,1'b0,1'b1, 1'b0,11'h000,16'h0000,16'h5555,11'h7FF};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,32'h0000_0000,3'd2,1'b1,1'b0, 1'b0,11'h000,16'h0000,16'h5555,11'h7FF};
`else
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,16'h0000,32'h0000_0000,3'd1,1'b0,1'b1, 1'b0,11'h000,16'h0000,16'hC0DE,11'h000};
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000,32'h0000_7777,3'd2,1'b1,1'b0, 1'b1,11'h000,16'h7777,16'hC0DE,11'h7FF};
`endif
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,16'hF820,32'h0000_0000,3'd3,1'b0,1'b1, 1'b0,11'h020,16'h0000,16'h1111,11'h7FF};

    for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;
    mem[0] = 16'hC0DE;

    // Reset, with a push request held to confirm dmem_we stays low
    clear_inputs();
    rst = 1'b1;
    push_in = 1'b1;
    @(negedge clk);
    chk("rst_we_low", {31'b0, dmem_we}, 32'd0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("rst_sp", {21'b0, sp_out}, 32'h7FF);
    chk("rst_data", {16'b0, Data_out}, 32'h0);
    chk("rst_wide", Data_wide_out, 32'h0);
    chk("rst_wvalid", {31'b0, wide_valid_out}, 32'd0);
    chk("rst_rdst1", {29'b0, Rdst1_out}, 32'd0);
    chk("rst_rlw", {31'b0, reglow_write_out}, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    chk("rst_we", {31'b0, dmem_we}, 32'd0);
`ifdef STACK_GUARD_EN
    chk("rst_fault", {31'b0, stack_fault}, 32'd0);
`endif

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      mem_read_in = vecs[i].rd; mem_write_in = vecs[i].wr;
      push_in = vecs[i].push; pop_in = vecs[i].pop; wide_in = 1'b0;
      addr_in = vecs[i].addr; store_data_in = vecs[i].sdata;
      Rdst1_in = vecs[i].rdst1; Rdst1_val_in = 16'h1000 + 16'(i);
      reglow_write_in = vecs[i].rlw; memToReg_in = vecs[i].mtr;
      #1;
      chk($sformatf("v%0d_we", i), {31'b0, dmem_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_addr", i), {21'b0, dmem_addr}, {21'b0, vecs[i].e_addr});
      if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), {16'b0, dmem_wdata}, {16'b0, vecs[i].e_wdata});
      chk($sformatf("v%0d_stall", i), {31'b0, stall_out}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_data", i), {16'b0, Data_out}, {16'b0, vecs[i].e_data});
      chk($sformatf("v%0d_sp", i), {21'b0, sp_out}, {21'b0, vecs[i].e_sp});
      chk($sformatf("v%0d_rdst1", i), {29'b0, Rdst1_out}, {29'b0, vecs[i].rdst1});
      chk($sformatf("v%0d_rval1", i), {16'b0, Rdst1_val_out}, 32'h1000 + i);
      chk($sformatf("v%0d_rlw", i), {31'b0, reglow_write_out}, {31'b0, vecs[i].rlw});
      chk($sformatf("v%0d_mtr", i), {31'b0, memToReg_out}, {31'b0, vecs[i].mtr});
      chk($sformatf("v%0d_wvalid", i), {31'b0, wide_valid_out}, 32'd0);
`ifdef STACK_GUARD_EN
      chk($sformatf("v%0d_fault", i), {31'b0, stack_fault}, (i == 8) ? 32'd1 : 32'd0);
`endif
    end

    @(negedge clk);
    clear_inputs();
    chk("mem_7ff", {16'b0, mem[11'h7FF]}, 32'h5555);
    chk("mem_010", {16'b0, mem[11'h010]}, 32'h00AA);
    chk("mem_020", {16'b0, mem[11'h020]}, 32'h1111);
    chk("mem_030_untouched", {16'b0, mem[11'h030]}, 32'h0000);
`ifdef STACK_GUARD_EN
    chk("mem_000", {16'b0, mem[11'h000]}, 32'hC0DE);
`else
    chk("mem_000", {16'b0, mem[11'h000]}, 32'h7777);
`endif

    // Wide push 32'h1234_5678 at SP=7FF
    push_in = 1'b1; wide_in = 1'b1; store_data_in = 32'h1234_5678;
    Rdst1_in = 3'd5; reglow_write_in = 1'b1; reghigh_write_in = 1'b1;
    #1;
    chk("wpush1_stall", {31'b0, stall_out}, 32'd1);
    chk("wpush1_we", {31'b0, dmem_we}, 32'd1);
    chk("wpush1_addr", {21'b0, dmem_addr}, 32'h7FF);
    chk("wpush1_wdata", {16'b0, dmem_wdata}, 32'h1234);
    @(posedge clk); #1;
    chk("wpush1_rlw_bubble", {31'b0, reglow_write_out}, 32'd0);
    chk("wpush1_rhw_bubble", {31'b0, reghigh_write_out}, 32'd0);
    chk("wpush1_sp", {21'b0, sp_out}, 32'h7FF);
    @(negedge clk); #1;
    chk("wpush2_stall", {31'b0, stall_out}, 32'd0);
    chk("wpush2_we", {31'b0, dmem_we}, 32'd1);
    chk("wpush2_addr", {21'b0, dmem_addr}, 32'h7FE);
    chk("wpush2_wdata", {16'b0, dmem_wdata}, 32'h5678);
    @(posedge clk); #1;
    chk("wpush2_rlw", {31'b0, reglow_write_out}, 32'd1);
    chk("wpush2_rhw", {31'b0, reghigh_write_out}, 32'd1);
    chk("wpush2_rdst1", {29'b0, Rdst1_out}, 32'd5);
    chk("wpush2_sp", {21'b0, sp_out}, 32'h7FD);
    @(negedge clk);
    chk("wpush_mem_7ff", {16'b0, mem[11'h7FF]}, 32'h1234);
    chk("wpush_mem_7fe", {16'b0, mem[11'h7FE]}, 32'h5678);

    // Wide pop back
    clear_inputs();
    pop_in = 1'b1; wide_in = 1'b1; reglow_write_in = 1'b1; reghigh_write_in = 1'b1; memToReg_in = 1'b1;
    #1;
    chk("wpop1_stall", {31'b0, stall_out}, 32'd1);
    chk("wpop1_we", {31'b0, dmem_we}, 32'd0);
    chk("wpop1_addr", {21'b0, dmem_addr}, 32'h7FE);
    @(posedge clk); #1;
    chk("wpop1_wvalid", {31'b0, wide_valid_out}, 32'd0);
    chk("wpop1_rlw_bubble", {31'b0, reglow_write_out}, 32'd0);
    chk("wpop1_sp", {21'b0, sp_out}, 32'h7FD);
    @(negedge clk); #1;
    chk("wpop2_stall", {31'b0, stall_out}, 32'd0);
    chk("wpop2_addr", {21'b0, dmem_addr}, 32'h7FF);
    @(posedge clk); #1;
    chk("wpop2_wide", Data_wide_out, 32'h1234_5678);
    chk("wpop2_wvalid", {31'b0, wide_valid_out}, 32'd1);
    chk("wpop2_data", {16'b0, Data_out}, 32'h5678);
    chk("wpop2_rlw", {31'b0, reglow_write_out}, 32'd1);
    chk("wpop2_sp", {21'b0, sp_out}, 32'h7FF);
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    chk("wpop_wvalid_drop", {31'b0, wide_valid_out}, 32'd0);

    // Reset asserted during the WIDE2 cycle of a wide push
    @(negedge clk);
    push_in = 1'b1; wide_in = 1'b1; store_data_in = 32'hAAAA_BBBB; Rdst1_in = 3'd6; reglow_write_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw_we", {31'b0, dmem_we}, 32'd0);
    @(posedge clk); #1;
    chk("rstw_sp", {21'b0, sp_out}, 32'h7FF);
    chk("rstw_data", {16'b0, Data_out}, 32'h0);
    chk("rstw_wide", Data_wide_out, 32'h0);
    chk("rstw_rdst1", {29'b0, Rdst1_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("rstw_stall", {31'b0, stall_out}, 32'd0);
    chk("rstw_mem_7ff", {16'b0, mem[11'h7FF]}, 32'hAAAA);
    chk("rstw_mem_7fe", {16'b0, mem[11'h7FE]}, 32'h5678);
    push_in = 1'b1; store_data_in = 32'h0000_4242;
    #1;
    chk("rstw_idle_stall", {31'b0, stall_out}, 32'd0);
    chk("rstw_idle_addr", {21'b0, dmem_addr}, 32'h7FF);
    @(posedge clk); #1;
    chk("rstw_idle_sp", {21'b0, sp_out}, 32'h7FE);
    @(negedge clk);
    clear_inputs();
    chk("rstw_push_mem", {16'b0, mem[11'h7FF]}, 32'h4242);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
